hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller. It is the producer side of the IF/ID write-enable, and it drives the freeze, flush and bubble controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It detects load-use hazards, control redirects and data-memory wait states, and it runs a memory-wait timeout FSM. The block sits beside the pipeline registers in the CPU top level.

---
 rtl/hazard_stall_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, redirect flushes, data-memory wait freeze
// with timeout FSM. Optional stall performance counter enabled by HAZARD_PERF_EN.
module hazard_stall_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemR,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PC_WR,
  output logic             IF_ID_WR,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_BUBBLE,
  output logic             EX_MEM_HOLD,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StMemWait, StErr} state_e;

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic load_use;
  logic mem_block;

  assign load_use = ex_MemR & (ex_rd != 5'd0) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign mem_block = mem_req & ~mem_ready;

  // Pipeline controls when memory is not holding the pipe
  logic run_pc_wr, run_if_id_wr, run_flush, run_bubble;

  always_comb begin
    run_pc_wr    = 1'b1;
    run_if_id_wr = 1'b1;
    run_flush    = 1'b0;
    run_bubble   = 1'b0;
    if (ex_redirect) begin
      // the ID instruction is squashed, so a pending load-use is irrelevant
      run_flush  = 1'b1;
      run_bubble = 1'b1;
    end else if (load_use) begin
      run_pc_wr    = 1'b0;
      run_if_id_wr = 1'b0;
      run_bubble   = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    PC_WR        = 1'b0;
    IF_ID_WR     = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_BUBBLE = 1'b0;
    EX_MEM_HOLD  = 1'b0;
    bus_err      = 1'b0;
    if (rst) begin
      ID_EX_BUBBLE = 1'b1;
      state_d      = StRun;
      wait_cnt_d   = 8'd0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (mem_block) begin
            EX_MEM_HOLD = 1'b1;
            state_d     = StMemWait;
            wait_cnt_d  = 8'd1;
          end else begin
            PC_WR        = run_pc_wr;
            IF_ID_WR     = run_if_id_wr;
            IF_ID_FLUSH  = run_flush;
            ID_EX_BUBBLE = run_bubble;
          end
        end
        StMemWait: begin
          if (mem_ready) begin
            PC_WR        = run_pc_wr;
            IF_ID_WR     = run_if_id_wr;
            IF_ID_FLUSH  = run_flush;
            ID_EX_BUBBLE = run_bubble;
            state_d      = StRun;
            wait_cnt_d   = 8'd0;
          end else begin
            EX_MEM_HOLD = 1'b1;
            if (wait_cnt_q == WaitLast) begin
              state_d = StErr;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end
        end
        StErr: begin
          EX_MEM_HOLD  = 1'b1;
          ID_EX_BUBBLE = 1'b1;
          bus_err      = 1'b1;
        end
        default: begin
          EX_MEM_HOLD  = 1'b1;
          ID_EX_BUBBLE = 1'b1;
          state_d      = StRun;
          wait_cnt_d   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where IF/ID is not written, excluding the error lockup
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!IF_ID_WR && (state_q != StErr) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
  localparam int MT    = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          id_uses_rt = 1'b0, ex_MemR = 1'b0, ex_redirect = 1'b0;
  logic          mem_req = 1'b0, mem_ready = 1'b0;
  logic          PC_WR, IF_ID_WR, IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_HOLD, bus_err;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_stall_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_MemR     (ex_MemR),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .PC_WR       (PC_WR),
    .IF_ID_WR    (IF_ID_WR),
    .IF_ID_FLUSH (IF_ID_FLUSH),
    .ID_EX_BUBBLE(ID_EX_BUBBLE),
    .EX_MEM_HOLD (EX_MEM_HOLD),
    .bus_err     (bus_err),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // {PC_WR, IF_ID_WR, IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_HOLD, bus_err}
  logic [5:0] ctl;
  assign ctl = {PC_WR, IF_ID_WR, IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_HOLD, bus_err};

  // Model: mode 0 = running, 1 = waiting on memory, 2 = locked in error
  int         m_mode = 0, m_frozen = 0, m_cnt = 0;
  int         n_mode, n_frozen, n_cnt;
  logic [5:0] exp_ctl;
  int         exp_cnt;

  task automatic model_eval();
    bit lu, freeze;
    lu = ex_MemR && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    freeze = (m_mode == 0 && mem_req && !mem_ready) || (m_mode == 1 && !mem_ready);
    n_mode = m_mode; n_frozen = m_frozen; n_cnt = m_cnt;
    if (rst) begin
      exp_ctl = 6'b000100; exp_cnt = 0;
      n_mode = 0; n_frozen = 0; n_cnt = 0;
    end else begin
      if (m_mode == 2)       exp_ctl = 6'b000111;
      else if (freeze)       exp_ctl = 6'b000010;
      else if (ex_redirect)  exp_ctl = 6'b111100;
      else if (lu)           exp_ctl = 6'b000100;
      else                   exp_ctl = 6'b110000;
      exp_cnt = PERF ? m_cnt : 0;
      if (m_mode != 2 && exp_ctl[4] == 1'b0 && m_cnt < CMAX) n_cnt = m_cnt + 1;
      if (freeze) begin
        n_frozen = m_frozen + 1;
        n_mode   = (n_frozen >= MT) ? 2 : 1;
      end else if (m_mode == 1) begin
        n_mode = 0; n_frozen = 0;
      end
    end
  endtask

  task automatic set_in(input bit r, input bit memr, input int rd, input int rs, input int rt,
                        input bit urt, input bit redir, input bit req, input bit rdy);
    @(negedge clk);
    rst = r; ex_MemR = memr; ex_rd = 5'(rd); id_rs = 5'(rs); id_rt = 5'(rt);
    id_uses_rt = urt; ex_redirect = redir; mem_req = req; mem_ready = rdy;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    m_mode = n_mode; m_frozen = n_frozen; m_cnt = n_cnt;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (ctl !== 6'b000100 || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: ctl=%b cnt=%0d want ctl=000100 cnt=0", ctl, stall_cnt);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
    n_tests++;
    if (ctl !== 6'b000100 || stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: ctl=%b cnt=%0d want ctl=000100 cnt=0", ctl, stall_cnt);
    end
    tick();
    idle();
    n_tests++;
    if (ctl !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_release: ctl=%b want 110000", ctl);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [5:0] want [5] = '{6'b000100, 6'b110000, 6'b110000, 6'b110000, 6'b000100};
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: set_in(0, 1, 5, 5, 0, 0, 0, 0, 0);
        1: idle();
        2: set_in(0, 1, 0, 0, 0, 1, 0, 0, 0);
        3: set_in(0, 1, 5, 1, 5, 0, 0, 0, 0);
        default: set_in(0, 1, 5, 1, 5, 1, 0, 0, 0);
      endcase
      n_tests++;
      if (ctl !== want[i]) begin
        n_fail++;
        $display("FAIL load_use[%0d]: ctl=%b want %b", i, ctl, want[i]);
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    set_in(0, 1, 3, 3, 0, 0, 1, 0, 0);
    n_tests++;
    if (ctl !== 6'b111100) begin
      n_fail++;
      $display("FAIL redirect_over_load_use: ctl=%b want 111100", ctl);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, (i == 3));
      n_tests++;
      if (ctl !== ((i == 3) ? 6'b110000 : 6'b000010)) begin
        n_fail++;
        $display("FAIL mem_wait[%0d]: ctl=%b want %b", i, ctl,
                 (i == 3) ? 6'b110000 : 6'b000010);
      end
      tick();
    end
    idle();
    n_tests++;
    if (stall_cnt !== CW'(PERF ? 3 : 0)) begin
      n_fail++;
      $display("FAIL mem_wait_cnt: cnt=%0d want %0d", stall_cnt, PERF ? 3 : 0);
    end
    tick();
  endtask

  task automatic test_timeout();
    pulse_reset();
    for (int i = 1; i <= 8; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, (i > 6));
      n_tests++;
      if (ctl !== ((i <= MT) ? 6'b000010 : 6'b000111)) begin
        n_fail++;
        $display("FAIL timeout[%0d]: ctl=%b want %b", i, ctl,
                 (i <= MT) ? 6'b000010 : 6'b000111);
      end
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    n_tests++;
    if (bus_err !== 1'b1 || stall_cnt !== CW'(PERF ? MT : 0)) begin
      n_fail++;
      $display("FAIL timeout_sticky: err=%b cnt=%0d want err=1 cnt=%0d", bus_err, stall_cnt,
               PERF ? MT : 0);
    end
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (ctl !== 6'b000100) begin
      n_fail++;
      $display("FAIL timeout_reset: ctl=%b want 000100", ctl);
    end
    tick();
  endtask

  task automatic test_saturation();
    int want;
    pulse_reset();
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) set_in(0, 1, 7, 7, 0, 0, 0, 0, 0);
      else        idle();
      want = PERF ? ((i > CMAX) ? CMAX : i) : 0;
      n_tests++;
      if (stall_cnt !== CW'(want)) begin
        n_fail++;
        $display("FAIL saturation[%0d]: cnt=%0d want %0d", i, stall_cnt, want);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 1));
      n_tests++;
      if (ctl !== exp_ctl || stall_cnt !== CW'(exp_cnt)) begin
        n_fail++;
        $display("FAIL random[%0d]: ctl=%b cnt=%0d want ctl=%b cnt=%0d", i, ctl, stall_cnt,
                 exp_ctl, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_saturation();
    pulse_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
